// File: rtl/qspi_flash_responder.sv
// SPI-flash target (mode 0, single lane) answering READ/FAST READ/RDID from a
// synchronous byte memory; all SPI inputs are oversampled on clk.
module qspi_flash_responder #(
  parameter int unsigned ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_csb,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [7:0]        last_cmd
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_sh8;
  logic [23:0]         r_sh24;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_prefetch;
  logic                r_rd_d;
  logic                r_miso;
  logic                r_oe;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_busy;
  logic [7:0]          r_last_cmd;

  logic              w_sclk;
  logic              w_csb;
  logic              w_mosi;
  logic              w_rise;
  logic              w_fall;
  logic [7:0]        w_cmd_byte;
  logic [23:0]       w_addr_word;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb       = r_csb_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  assign w_cmd_byte  = {r_sh8[6:0], w_mosi};
  assign w_addr_word = {r_sh24[22:0], w_mosi};
  assign w_addr_next = r_addr + ADDR_W'(1);

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign busy        = r_busy;
  assign last_cmd    = r_last_cmd;

  // Synchronizers; csb resets deasserted so the target starts idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_csb_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], spi_csb};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= w_sclk;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sh8      <= '0;
      r_sh24     <= '0;
      r_addr     <= '0;
      r_prefetch <= '0;
      r_rd_d     <= 1'b0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_last_cmd <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      r_rd_d   <= r_mem_rd;
      // Read data still lands after an abort; the next fetch overwrites it.
      if (r_rd_d) r_prefetch <= mem_rdata;

      if (w_csb) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_oe    <= 1'b0;
        r_miso  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CMD;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
          S_CMD: if (w_rise) begin
            r_sh8 <= w_cmd_byte;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(7)) begin
              r_cnt      <= '0;
              r_last_cmd <= w_cmd_byte;
              case (w_cmd_byte)
                8'h03, 8'h0B: r_state <= S_ADDR;
                8'h9F: begin
                  r_state <= S_ID;
                  r_sh24  <= JEDEC_ID;
                end
                default: r_state <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: if (w_rise) begin
            r_sh24 <= w_addr_word;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(23)) begin
              r_cnt      <= '0;
              r_addr     <= w_addr_word[ADDR_W-1:0];
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_addr_word[ADDR_W-1:0];
              r_state    <= (r_last_cmd == 8'h0B) ? S_DUMMY : S_DATA;
            end
          end
          S_DUMMY: if (w_rise) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(7)) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end
          end
          S_DATA: if (w_fall) begin
            r_oe <= 1'b1;
            // Bit 7 of each byte comes straight from the prefetch register.
            if (r_cnt == '0) begin
              r_miso <= r_prefetch[7];
              r_sh8  <= {r_prefetch[6:0], 1'b0};
            end else begin
              r_miso <= r_sh8[7];
              r_sh8  <= {r_sh8[6:0], 1'b0};
            end
            if (r_cnt == CNT_W'(7)) begin
              r_cnt      <= '0;
              r_addr     <= w_addr_next;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_addr_next;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_ID: if (w_fall) begin
            r_oe   <= 1'b1;
            r_miso <= r_sh24[23];
            r_sh24 <= {r_sh24[22:0], r_sh24[23]};
          end
          S_IGNORE: r_oe <= 1'b0;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: a 24-bit instance and an 8-bit
// address instance sharing the SPI clock/data lines with separate chip selects.
module tb_qspi_flash_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk;
  logic        spi_mosi;
  logic        csb0, csb1;
  logic        miso0, miso1, oe0, oe1;
  logic        mem_rd0, mem_rd1;
  logic [23:0] mem_addr0;
  logic [7:0]  mem_addr1;
  logic [7:0]  mem_rdata0, mem_rdata1;
  logic        busy0, busy1;
  logic [7:0]  last_cmd0, last_cmd1;

  int checks = 0;
  int errors = 0;
  int consec = 0;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  qspi_flash_responder #(.ADDR_W(24)) dut0 (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_csb(csb0), .spi_mosi(spi_mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .mem_rd(mem_rd0), .mem_addr(mem_addr0),
    .mem_rdata(mem_rdata0), .busy(busy0), .last_cmd(last_cmd0));

  qspi_flash_responder #(.ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_csb(csb1), .spi_mosi(spi_mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1), .mem_rd(mem_rd1), .mem_addr(mem_addr1),
    .mem_rdata(mem_rdata1), .busy(busy1), .last_cmd(last_cmd1));

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h000010: mem_val = 8'hA5;
      24'h000011: mem_val = 8'h5A;
      24'h000012: mem_val = 8'hC3;
      24'h000013: mem_val = 8'h3C;
      24'h000000: mem_val = 8'h12;
      24'h000020: mem_val = 8'h77;
      default:    mem_val = a[7:0] ^ 8'h96;
    endcase
  endfunction

  // Memory returns data exactly one clk after the strobe.
  always @(posedge clk) begin
    mem_rdata0 <= mem_rd0 ? mem_val(mem_addr0) : 8'h00;
    mem_rdata1 <= mem_rd1 ? mem_val({16'h0000, mem_addr1}) : 8'h00;
  end

  always @(negedge clk) begin
    if (mem_rd0) q0.push_back(32'(mem_addr0));
    if (mem_rd1) q1.push_back(32'(mem_addr1));
    if ((mem_rd0 && prev0) || (mem_rd1 && prev1)) consec++;
    prev0 = mem_rd0;
    prev1 = mem_rd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0 bit cycle: MOSI set while clk low, MISO sampled just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, input logic sel,
                          output logic [7:0] rx, output logic oe_any, output logic oe_all);
    rx = '0; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      #80;
      rx = {rx[6:0], (sel ? miso1 : miso0)};
      oe_any = oe_any | (sel ? oe1 : oe0);
      oe_all = oe_all & (sel ? oe1 : oe0);
      spi_clk = 1'b1;
      #80;
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic sel);
    logic [7:0] rx; logic oa, ol;
    spi_bits(b, 8, sel, rx, oa, ol);
    check({tag, "_oe"}, 32'(oa), 32'd0);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp, input logic sel);
    logic [7:0] rx; logic oa, ol;
    spi_bits(8'h00, 8, sel, rx, oa, ol);
    check(tag, 32'(rx), 32'(exp));
    check({tag, "_oe"}, 32'(ol), 32'd1);
  endtask

  task automatic begin_tx(input logic sel);
    if (sel) csb1 = 1'b0; else csb0 = 1'b0;
    #80;
  endtask

  task automatic end_tx(input logic sel);
    if (sel) csb1 = 1'b1; else csb0 = 1'b1;
    #100;
  endtask

  task automatic send_read(input string tag, input logic [7:0] op, input logic [23:0] a,
                           input logic sel);
    send({tag, "_op"}, op, sel);
    send({tag, "_a2"}, a[23:16], sel);
    send({tag, "_a1"}, a[15:8], sel);
    send({tag, "_a0"}, a[7:0], sel);
  endtask

  initial begin
    logic [7:0] rx;
    logic oa, ol;
    logic [7:0] id_seq [6];
    id_seq = '{8'hEF, 8'h40, 8'h18, 8'hEF, 8'h40, 8'h18};

    reset = 1'b1; csb0 = 1'b1; csb1 = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    #30;
    check("rst_miso", 32'(miso0), 32'd0);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_mem_rd", 32'(mem_rd0), 32'd0);
    check("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_last_cmd", 32'(last_cmd0), 32'd0);
    reset = 1'b0;
    #40;

    // READ 03 at 0x000010, four bytes
    q0.delete();
    begin_tx(1'b0);
    send_read("rd", 8'h03, 24'h000010, 1'b0);
    check("rd_busy", 32'(busy0), 32'd1);
    check("rd_last_cmd_mid", 32'(last_cmd0), 32'h03);
    rd_byte("rd_b0", 8'hA5, 1'b0);
    rd_byte("rd_b1", 8'h5A, 1'b0);
    rd_byte("rd_b2", 8'hC3, 1'b0);
    rd_byte("rd_b3", 8'h3C, 1'b0);
    end_tx(1'b0);
    check("rd_nrd", 32'(q0.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("rd_addr_seq", (i < q0.size()) ? q0[i] : 32'hDEADBEEF, 32'h10 + 32'(i));
    check("rd_oe_end", 32'(oe0), 32'd0);
    check("rd_busy_end", 32'(busy0), 32'd0);

    // FAST READ 0B at 0x000000 with dummy byte
    q0.delete();
    begin_tx(1'b0);
    send_read("fr", 8'h0B, 24'h000000, 1'b0);
    spi_bits(8'h00, 8, 1'b0, rx, oa, ol);
    check("fr_dummy_oe", 32'(oa), 32'd0);
    rd_byte("fr_b0", 8'h12, 1'b0);
    end_tx(1'b0);
    check("fr_last_cmd", 32'(last_cmd0), 32'h0B);
    check("fr_first_addr", (q0.size() > 0) ? q0[0] : 32'hDEADBEEF, 32'h0);

    // RDID
    q0.delete();
    begin_tx(1'b0);
    send("id_op", 8'h9F, 1'b0);
    for (int i = 0; i < 6; i++) rd_byte("id_byte", id_seq[i], 1'b0);
    end_tx(1'b0);
    check("id_no_rd", 32'(q0.size()), 32'd0);
    check("id_last_cmd", 32'(last_cmd0), 32'h9F);

    // Address wrap on the 8-bit instance
    q0.delete(); q1.delete();
    begin_tx(1'b1);
    send_read("wr", 8'h03, 24'h0000FE, 1'b1);
    rd_byte("wr_b0", 8'h68, 1'b1);
    rd_byte("wr_b1", 8'h69, 1'b1);
    rd_byte("wr_b2", 8'h12, 1'b1);
    end_tx(1'b1);
    check("wr_nrd", 32'(q1.size()), 32'd4);
    check("wr_a0", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'hFE);
    check("wr_a1", (q1.size() > 1) ? q1[1] : 32'hDEADBEEF, 32'hFF);
    check("wr_a2", (q1.size() > 2) ? q1[2] : 32'hDEADBEEF, 32'h00);
    check("wr_dut0_quiet", 32'(q0.size()), 32'd0);

    // Abort after 12 address bits, then a clean read
    q0.delete();
    begin_tx(1'b0);
    send("ab_op", 8'h03, 1'b0);
    send("ab_a2", 8'h00, 1'b0);
    spi_bits(8'h00, 4, 1'b0, rx, oa, ol);
    check("ab_busy_mid", 32'(busy0), 32'd1);
    csb0 = 1'b1;
    #50;
    check("ab_busy", 32'(busy0), 32'd0);
    check("ab_oe", 32'(oe0), 32'd0);
    check("ab_no_rd", 32'(q0.size()), 32'd0);
    #50;
    begin_tx(1'b0);
    send_read("ab2", 8'h03, 24'h000020, 1'b0);
    rd_byte("ab2_b0", 8'h77, 1'b0);
    end_tx(1'b0);

    // Unknown opcode
    q0.delete();
    begin_tx(1'b0);
    send("un_op", 8'h5A, 1'b0);
    spi_bits(8'hFF, 8, 1'b0, rx, oa, ol);
    check("un_oe0", 32'(oa), 32'd0);
    spi_bits(8'h03, 8, 1'b0, rx, oa, ol);
    check("un_oe1", 32'(oa), 32'd0);
    check("un_busy", 32'(busy0), 32'd1);
    end_tx(1'b0);
    check("un_last_cmd", 32'(last_cmd0), 32'h5A);
    check("un_no_rd", 32'(q0.size()), 32'd0);

    // Async reset in the middle of DATA
    begin_tx(1'b0);
    send_read("rs", 8'h03, 24'h000010, 1'b0);
    rd_byte("rs_b0", 8'hA5, 1'b0);
    check("rs_pre_busy", 32'(busy0), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("rs_miso", 32'(miso0), 32'd0);
    check("rs_oe", 32'(oe0), 32'd0);
    check("rs_mem_rd", 32'(mem_rd0), 32'd0);
    check("rs_mem_addr", 32'(mem_addr0), 32'd0);
    check("rs_busy", 32'(busy0), 32'd0);
    check("rs_last_cmd", 32'(last_cmd0), 32'd0);
    #6;
    csb0 = 1'b1;
    #40;
    reset = 1'b0;
    #40;

    // Fresh transaction after reset
    q0.delete();
    begin_tx(1'b0);
    send_read("pr", 8'h03, 24'h000013, 1'b0);
    rd_byte("pr_b0", 8'h3C, 1'b0);
    end_tx(1'b0);
    check("pr_last_cmd", 32'(last_cmd0), 32'h03);
    check("pr_first_addr", (q0.size() > 0) ? q0[0] : 32'hDEADBEEF, 32'h13);

    check("rd_consecutive", 32'(consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
